// File: rtl/axi_master_arbiter.sv
// Two-master AXI4 arbiter (m0 = IFU, m1 = LSU) onto one downstream port; read and write arbitrated independently.
// Define ARB_RR_EN for per-channel round-robin; otherwise fixed priority m1 > m0.
module axi_master_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clock,
  input  logic                reset,
  // master 0 (IFU)
  input  logic                m0_arvalid,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic [ID_W-1:0]     m0_arid,
  input  logic [7:0]          m0_arlen,
  input  logic [2:0]          m0_arsize,
  input  logic [1:0]          m0_arburst,
  output logic                m0_arready,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rlast,
  output logic [ID_W-1:0]     m0_rid,
  input  logic                m0_rready,
  input  logic                m0_awvalid,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic [ID_W-1:0]     m0_awid,
  input  logic [7:0]          m0_awlen,
  input  logic [2:0]          m0_awsize,
  input  logic [1:0]          m0_awburst,
  output logic                m0_awready,
  input  logic                m0_wvalid,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wlast,
  output logic                m0_wready,
  output logic                m0_bvalid,
  output logic [1:0]          m0_bresp,
  output logic [ID_W-1:0]     m0_bid,
  input  logic                m0_bready,
  // master 1 (LSU)
  input  logic                m1_arvalid,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic [ID_W-1:0]     m1_arid,
  input  logic [7:0]          m1_arlen,
  input  logic [2:0]          m1_arsize,
  input  logic [1:0]          m1_arburst,
  output logic                m1_arready,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rlast,
  output logic [ID_W-1:0]     m1_rid,
  input  logic                m1_rready,
  input  logic                m1_awvalid,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [ID_W-1:0]     m1_awid,
  input  logic [7:0]          m1_awlen,
  input  logic [2:0]          m1_awsize,
  input  logic [1:0]          m1_awburst,
  output logic                m1_awready,
  input  logic                m1_wvalid,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wlast,
  output logic                m1_wready,
  output logic                m1_bvalid,
  output logic [1:0]          m1_bresp,
  output logic [ID_W-1:0]     m1_bid,
  input  logic                m1_bready,
  // downstream port
  output logic                io_master_arvalid,
  output logic [ADDR_W-1:0]   io_master_araddr,
  output logic [ID_W-1:0]     io_master_arid,
  output logic [7:0]          io_master_arlen,
  output logic [2:0]          io_master_arsize,
  output logic [1:0]          io_master_arburst,
  input  logic                io_master_arready,
  input  logic                io_master_rvalid,
  input  logic [DATA_W-1:0]   io_master_rdata,
  input  logic [1:0]          io_master_rresp,
  input  logic                io_master_rlast,
  input  logic [ID_W-1:0]     io_master_rid,
  output logic                io_master_rready,
  output logic                io_master_awvalid,
  output logic [ADDR_W-1:0]   io_master_awaddr,
  output logic [ID_W-1:0]     io_master_awid,
  output logic [7:0]          io_master_awlen,
  output logic [2:0]          io_master_awsize,
  output logic [1:0]          io_master_awburst,
  input  logic                io_master_awready,
  output logic                io_master_wvalid,
  output logic [DATA_W-1:0]   io_master_wdata,
  output logic [DATA_W/8-1:0] io_master_wstrb,
  output logic                io_master_wlast,
  input  logic                io_master_wready,
  input  logic                io_master_bvalid,
  input  logic [1:0]          io_master_bresp,
  input  logic [ID_W-1:0]     io_master_bid,
  output logic                io_master_bready,
  // FSM state observation: read 0=IDLE 1=ADDR 2=DATA; write 0=IDLE 1=ADDR 2=DATA 3=RESP
  output logic [1:0]          o_dbg_rstate,
  output logic [1:0]          o_dbg_wstate
);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rstate_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wstate_t;

  // Grants are one-hot {m1, m0}; 2'b00 means no grant (only while the FSM is idle).
  rstate_t     r_rstate, w_rstate_nxt;
  wstate_t     r_wstate, w_wstate_nxt;
  logic [1:0]  r_rgnt, w_rgnt_nxt;
  logic [1:0]  r_wgnt, w_wgnt_nxt;
  logic        w_rpick_m1, w_wpick_m1;

  // Handshakes: a transfer happens in a cycle where both valid and ready are high at the clock edge.
`ifdef ARB_RR_EN
  logic r_rptr, r_wptr;  // 1 = favour m1 on a tie

  assign w_rpick_m1 = m1_arvalid && (!m0_arvalid || r_rptr);
  assign w_wpick_m1 = m1_awvalid && (!m0_awvalid || r_wptr);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rptr <= 1'b0;
      r_wptr <= 1'b0;
    end else begin
      if (r_rstate == R_DATA && w_rstate_nxt == R_IDLE) r_rptr <= r_rgnt[0];
      if (r_wstate == W_RESP && w_wstate_nxt == W_IDLE) r_wptr <= r_wgnt[0];
    end
  end
`else
  assign w_rpick_m1 = m1_arvalid;
  assign w_wpick_m1 = m1_awvalid;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rstate <= R_IDLE;
      r_wstate <= W_IDLE;
      r_rgnt   <= 2'b00;
      r_wgnt   <= 2'b00;
    end else begin
      r_rstate <= w_rstate_nxt;
      r_wstate <= w_wstate_nxt;
      r_rgnt   <= w_rgnt_nxt;
      r_wgnt   <= w_wgnt_nxt;
    end
  end

  assign o_dbg_rstate = r_rstate;
  assign o_dbg_wstate = r_wstate;

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rgnt_nxt   = r_rgnt;
    io_master_arvalid = 1'b0; io_master_araddr = '0; io_master_arid = '0;
    io_master_arlen = '0; io_master_arsize = '0; io_master_arburst = '0;
    io_master_rready = 1'b0;
    m0_arready = 1'b0; m1_arready = 1'b0;
    m0_rvalid = 1'b0; m0_rdata = '0; m0_rresp = '0; m0_rlast = 1'b0; m0_rid = '0;
    m1_rvalid = 1'b0; m1_rdata = '0; m1_rresp = '0; m1_rlast = 1'b0; m1_rid = '0;
    case (r_rstate)
      R_IDLE: if (m0_arvalid || m1_arvalid) begin
        w_rgnt_nxt   = w_rpick_m1 ? 2'b10 : 2'b01;
        w_rstate_nxt = R_ADDR;
      end
      R_ADDR: begin
        if (r_rgnt[1]) begin
          io_master_arvalid = m1_arvalid; io_master_araddr = m1_araddr; io_master_arid = m1_arid;
          io_master_arlen = m1_arlen; io_master_arsize = m1_arsize; io_master_arburst = m1_arburst;
          m1_arready = io_master_arready;
        end else begin
          io_master_arvalid = m0_arvalid; io_master_araddr = m0_araddr; io_master_arid = m0_arid;
          io_master_arlen = m0_arlen; io_master_arsize = m0_arsize; io_master_arburst = m0_arburst;
          m0_arready = io_master_arready;
        end
        if (io_master_arvalid && io_master_arready) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        if (r_rgnt[1]) begin
          m1_rvalid = io_master_rvalid; m1_rdata = io_master_rdata; m1_rresp = io_master_rresp;
          m1_rlast = io_master_rlast; m1_rid = io_master_rid;
          io_master_rready = m1_rready;
        end else begin
          m0_rvalid = io_master_rvalid; m0_rdata = io_master_rdata; m0_rresp = io_master_rresp;
          m0_rlast = io_master_rlast; m0_rid = io_master_rid;
          io_master_rready = m0_rready;
        end
        // Completion follows rlast only; len/burst are never counted here.
        if (io_master_rvalid && io_master_rready && io_master_rlast) begin
          w_rstate_nxt = R_IDLE;
          w_rgnt_nxt   = 2'b00;
        end
      end
      default: begin
        w_rstate_nxt = R_IDLE;
        w_rgnt_nxt   = 2'b00;
      end
    endcase
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wgnt_nxt   = r_wgnt;
    io_master_awvalid = 1'b0; io_master_awaddr = '0; io_master_awid = '0;
    io_master_awlen = '0; io_master_awsize = '0; io_master_awburst = '0;
    io_master_wvalid = 1'b0; io_master_wdata = '0; io_master_wstrb = '0; io_master_wlast = 1'b0;
    io_master_bready = 1'b0;
    m0_awready = 1'b0; m1_awready = 1'b0; m0_wready = 1'b0; m1_wready = 1'b0;
    m0_bvalid = 1'b0; m0_bresp = '0; m0_bid = '0;
    m1_bvalid = 1'b0; m1_bresp = '0; m1_bid = '0;
    case (r_wstate)
      W_IDLE: if (m0_awvalid || m1_awvalid) begin
        w_wgnt_nxt   = w_wpick_m1 ? 2'b10 : 2'b01;
        w_wstate_nxt = W_ADDR;
      end
      W_ADDR: begin
        if (r_wgnt[1]) begin
          io_master_awvalid = m1_awvalid; io_master_awaddr = m1_awaddr; io_master_awid = m1_awid;
          io_master_awlen = m1_awlen; io_master_awsize = m1_awsize; io_master_awburst = m1_awburst;
          m1_awready = io_master_awready;
        end else begin
          io_master_awvalid = m0_awvalid; io_master_awaddr = m0_awaddr; io_master_awid = m0_awid;
          io_master_awlen = m0_awlen; io_master_awsize = m0_awsize; io_master_awburst = m0_awburst;
          m0_awready = io_master_awready;
        end
        if (io_master_awvalid && io_master_awready) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        if (r_wgnt[1]) begin
          io_master_wvalid = m1_wvalid; io_master_wdata = m1_wdata;
          io_master_wstrb = m1_wstrb; io_master_wlast = m1_wlast;
          m1_wready = io_master_wready;
        end else begin
          io_master_wvalid = m0_wvalid; io_master_wdata = m0_wdata;
          io_master_wstrb = m0_wstrb; io_master_wlast = m0_wlast;
          m0_wready = io_master_wready;
        end
        if (io_master_wvalid && io_master_wready && io_master_wlast) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        if (r_wgnt[1]) begin
          m1_bvalid = io_master_bvalid; m1_bresp = io_master_bresp; m1_bid = io_master_bid;
          io_master_bready = m1_bready;
        end else begin
          m0_bvalid = io_master_bvalid; m0_bresp = io_master_bresp; m0_bid = io_master_bid;
          io_master_bready = m0_bready;
        end
        if (io_master_bvalid && io_master_bready) begin
          w_wstate_nxt = W_IDLE;
          w_wgnt_nxt   = 2'b00;
        end
      end
      default: begin
        w_wstate_nxt = W_IDLE;
        w_wgnt_nxt   = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter: drivers push expectations into queues, a negedge monitor pops and compares.
module tb_axi_master_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic m0_arvalid, m0_arready, m0_rvalid, m0_rlast, m0_rready;
  logic [31:0] m0_araddr, m0_rdata; logic [3:0] m0_arid, m0_rid;
  logic [7:0] m0_arlen; logic [2:0] m0_arsize; logic [1:0] m0_arburst, m0_rresp;
  logic m0_awvalid, m0_awready, m0_wvalid, m0_wlast, m0_wready, m0_bvalid, m0_bready;
  logic [31:0] m0_awaddr, m0_wdata; logic [3:0] m0_awid, m0_wstrb, m0_bid;
  logic [7:0] m0_awlen; logic [2:0] m0_awsize; logic [1:0] m0_awburst, m0_bresp;
  logic m1_arvalid, m1_arready, m1_rvalid, m1_rlast, m1_rready;
  logic [31:0] m1_araddr, m1_rdata; logic [3:0] m1_arid, m1_rid;
  logic [7:0] m1_arlen; logic [2:0] m1_arsize; logic [1:0] m1_arburst, m1_rresp;
  logic m1_awvalid, m1_awready, m1_wvalid, m1_wlast, m1_wready, m1_bvalid, m1_bready;
  logic [31:0] m1_awaddr, m1_wdata; logic [3:0] m1_awid, m1_wstrb, m1_bid;
  logic [7:0] m1_awlen; logic [2:0] m1_awsize; logic [1:0] m1_awburst, m1_bresp;
  logic io_master_arvalid, io_master_arready, io_master_rvalid, io_master_rlast, io_master_rready;
  logic [31:0] io_master_araddr, io_master_rdata; logic [3:0] io_master_arid, io_master_rid;
  logic [7:0] io_master_arlen; logic [2:0] io_master_arsize; logic [1:0] io_master_arburst, io_master_rresp;
  logic io_master_awvalid, io_master_awready, io_master_wvalid, io_master_wlast, io_master_wready;
  logic io_master_bvalid, io_master_bready;
  logic [31:0] io_master_awaddr, io_master_wdata; logic [3:0] io_master_awid, io_master_wstrb, io_master_bid;
  logic [7:0] io_master_awlen; logic [2:0] io_master_awsize; logic [1:0] io_master_awburst, io_master_bresp;
  logic [1:0] o_dbg_rstate, o_dbg_wstate;

  axi_master_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
    .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m0_rid(m0_rid), .m0_rready(m0_rready),
    .m0_awvalid(m0_awvalid), .m0_awaddr(m0_awaddr), .m0_awid(m0_awid), .m0_awlen(m0_awlen),
    .m0_awsize(m0_awsize), .m0_awburst(m0_awburst), .m0_awready(m0_awready),
    .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
    .m0_wready(m0_wready), .m0_bvalid(m0_bvalid), .m0_bresp(m0_bresp), .m0_bid(m0_bid),
    .m0_bready(m0_bready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
    .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_rid(m1_rid), .m1_rready(m1_rready),
    .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid), .m1_awlen(m1_awlen),
    .m1_awsize(m1_awsize), .m1_awburst(m1_awburst), .m1_awready(m1_awready),
    .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
    .m1_wready(m1_wready), .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bid(m1_bid),
    .m1_bready(m1_bready),
    .io_master_arvalid(io_master_arvalid), .io_master_araddr(io_master_araddr),
    .io_master_arid(io_master_arid), .io_master_arlen(io_master_arlen),
    .io_master_arsize(io_master_arsize), .io_master_arburst(io_master_arburst),
    .io_master_arready(io_master_arready), .io_master_rvalid(io_master_rvalid),
    .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp),
    .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid),
    .io_master_rready(io_master_rready),
    .io_master_awvalid(io_master_awvalid), .io_master_awaddr(io_master_awaddr),
    .io_master_awid(io_master_awid), .io_master_awlen(io_master_awlen),
    .io_master_awsize(io_master_awsize), .io_master_awburst(io_master_awburst),
    .io_master_awready(io_master_awready), .io_master_wvalid(io_master_wvalid),
    .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
    .io_master_wlast(io_master_wlast), .io_master_wready(io_master_wready),
    .io_master_bvalid(io_master_bvalid), .io_master_bresp(io_master_bresp),
    .io_master_bid(io_master_bid), .io_master_bready(io_master_bready),
    .o_dbg_rstate(o_dbg_rstate), .o_dbg_wstate(o_dbg_wstate)
  );

  // scoreboard queues: ar/aw {len,id,addr}; r {last,id,data}; w {last,strb,data}; b {resp,id}
  logic [43:0] exp_ar_q[$], exp_aw_q[$];
  logic [36:0] exp_r0_q[$], exp_r1_q[$], exp_w_q[$];
  logic [5:0]  exp_b0_q[$], exp_b1_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset) begin
      if (io_master_arvalid && io_master_arready) begin
        if (exp_ar_q.size() == 0) chk("ar_unexpected", 1, 0);
        else chk("ar_fwd", {io_master_arlen, io_master_arid, io_master_araddr}, exp_ar_q.pop_front());
      end
      if (io_master_awvalid && io_master_awready) begin
        if (exp_aw_q.size() == 0) chk("aw_unexpected", 1, 0);
        else chk("aw_fwd", {io_master_awlen, io_master_awid, io_master_awaddr}, exp_aw_q.pop_front());
      end
      if (io_master_wvalid && io_master_wready) begin
        if (exp_w_q.size() == 0) chk("w_unexpected", 1, 0);
        else chk("w_fwd", {io_master_wlast, io_master_wstrb, io_master_wdata}, exp_w_q.pop_front());
      end
      if (m0_rvalid) begin
        if (exp_r0_q.size() == 0) chk("m0_r_unexpected", 1, 0);
        else if (m0_rready) chk("m0_r_beat", {m0_rlast, m0_rid, m0_rdata}, exp_r0_q.pop_front());
      end
      if (m1_rvalid) begin
        if (exp_r1_q.size() == 0) chk("m1_r_unexpected", 1, 0);
        else if (m1_rready) chk("m1_r_beat", {m1_rlast, m1_rid, m1_rdata}, exp_r1_q.pop_front());
      end
      if (m0_bvalid) begin
        if (exp_b0_q.size() == 0) chk("m0_b_unexpected", 1, 0);
        else if (m0_bready) chk("m0_b", {m0_bresp, m0_bid}, exp_b0_q.pop_front());
      end
      if (m1_bvalid) begin
        if (exp_b1_q.size() == 0) chk("m1_b_unexpected", 1, 0);
        else if (m1_bready) chk("m1_b", {m1_bresp, m1_bid}, exp_b1_q.pop_front());
      end
    end
  end

  // ---------------- drivers (masters at posedge+1, slave at posedge+2) ----------------
  task automatic ar_req(input bit m, input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    bit hs = 0;
    int g = 0;
    if (m) begin
      m1_arvalid = 1; m1_araddr = addr; m1_arid = id; m1_arlen = len; m1_arsize = 3'd2; m1_arburst = 2'b01;
    end else begin
      m0_arvalid = 1; m0_araddr = addr; m0_arid = id; m0_arlen = len; m0_arsize = 3'd2; m0_arburst = 2'b01;
    end
    while (!hs && g < 100) begin
      @(negedge clock);
      hs = m ? (m1_arvalid && m1_arready) : (m0_arvalid && m0_arready);
      @(posedge clock); #1;
      g++;
    end
    chk("ar_req_done", hs, 1);
    if (m) m1_arvalid = 0; else m0_arvalid = 0;
  endtask

  task automatic aw_req(input bit m, input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    bit hs = 0;
    int g = 0;
    if (m) begin
      m1_awvalid = 1; m1_awaddr = addr; m1_awid = id; m1_awlen = len; m1_awsize = 3'd2; m1_awburst = 2'b01;
    end else begin
      m0_awvalid = 1; m0_awaddr = addr; m0_awid = id; m0_awlen = len; m0_awsize = 3'd2; m0_awburst = 2'b01;
    end
    while (!hs && g < 100) begin
      @(negedge clock);
      hs = m ? (m1_awvalid && m1_awready) : (m0_awvalid && m0_awready);
      @(posedge clock); #1;
      g++;
    end
    chk("aw_req_done", hs, 1);
    if (m) m1_awvalid = 0; else m0_awvalid = 0;
  endtask

  task automatic w_send(input bit m, input int n, input logic [31:0] base, input logic [3:0] strb);
    for (int i = 0; i < n; i++) begin
      bit hs = 0;
      int g = 0;
      if (m) begin m1_wvalid = 1; m1_wdata = base + i; m1_wstrb = strb; m1_wlast = (i == n - 1); end
      else   begin m0_wvalid = 1; m0_wdata = base + i; m0_wstrb = strb; m0_wlast = (i == n - 1); end
      while (!hs && g < 100) begin
        @(negedge clock);
        hs = m ? (m1_wvalid && m1_wready) : (m0_wvalid && m0_wready);
        @(posedge clock); #1;
        g++;
      end
      chk("w_beat_done", hs, 1);
    end
    if (m) begin m1_wvalid = 0; m1_wlast = 0; end else begin m0_wvalid = 0; m0_wlast = 0; end
  endtask

  task automatic slave_r(input int n, input logic [31:0] base, input logic [3:0] id, input bit lastf);
    for (int i = 0; i < n; i++) begin
      bit hs = 0;
      int g = 0;
      io_master_rvalid = 1; io_master_rdata = base + i; io_master_rid = id; io_master_rresp = 2'b00;
      io_master_rlast = lastf && (i == n - 1);
      while (!hs && g < 100) begin
        @(negedge clock);
        hs = io_master_rvalid && io_master_rready;
        @(posedge clock); #2;
        g++;
      end
      chk("r_beat_done", hs, 1);
    end
    io_master_rvalid = 0; io_master_rlast = 0;
  endtask

  // wready follows pat[k] on each cycle the downstream sees wvalid (1 beyond bit 7)
  task automatic slave_w(input logic [7:0] pat, input int n);
    int got = 0;
    int k = 0;
    int g = 0;
    while (got < n && g < 100) begin
      @(posedge clock); #2;
      if (io_master_wvalid) begin
        io_master_wready = (k < 8) ? pat[k] : 1'b1;
        k++;
      end else io_master_wready = 0;
      @(negedge clock);
      if (io_master_wvalid && io_master_wready) got++;
      g++;
    end
    @(posedge clock); #2;
    io_master_wready = 0;
    chk("w_beats_done", got, n);
  endtask

  task automatic slave_b(input int dly, input logic [1:0] resp, input logic [3:0] id);
    bit seen = 0;
    bit hs = 0;
    int g = 0;
    while (!seen && g < 100) begin
      @(negedge clock);
      seen = io_master_wvalid && io_master_wready && io_master_wlast;
      g++;
    end
    repeat (dly) @(posedge clock);
    #2;
    io_master_bvalid = 1; io_master_bresp = resp; io_master_bid = id;
    g = 0;
    while (!hs && g < 100) begin
      @(negedge clock);
      hs = io_master_bvalid && io_master_bready;
      @(posedge clock); #2;
      g++;
    end
    io_master_bvalid = 0;
    chk("b_done", seen && hs, 1);
  endtask

  task automatic watch_t4();
    bit seen = 0;
    int viol = 0;
    int cyc = 0;
    int g = 0;
    while (g < 60) begin
      @(negedge clock);
      g++;
      if (!seen) begin
        if (m1_arready) viol++;
        if (m0_rvalid && m0_rready && m0_rlast) seen = 1;
      end else begin
        cyc++;
        if (io_master_arvalid && io_master_arid == 4'h7) break;
      end
    end
    chk("t4_m1_arready_low", viol, 0);
    chk("t4_rlast_seen", seen, 1);
    chk("t4_bubble_cycles", cyc, 2);
  endtask

  task automatic watch_t6();
    int nb = 0;
    int g = 0;
    bit hs;
    while (nb < 3 && g < 60) begin
      @(negedge clock);
      hs = io_master_wvalid && io_master_wready;
      @(posedge clock); #1;
      g++;
      if (hs) begin
        nb++;
        if (nb < 3) chk("t6_still_wdata", o_dbg_wstate, 2);
        else chk("t6_wresp_after_wlast", o_dbg_wstate, 3);
      end
    end
    chk("t6_beats", nb, 3);
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit first_m1;
    {m0_arvalid, m0_araddr, m0_arid, m0_arlen, m0_arsize, m0_arburst, m0_rready} = '0;
    {m0_awvalid, m0_awaddr, m0_awid, m0_awlen, m0_awsize, m0_awburst} = '0;
    {m0_wvalid, m0_wdata, m0_wstrb, m0_wlast, m0_bready} = '0;
    {m1_arvalid, m1_araddr, m1_arid, m1_arlen, m1_arsize, m1_arburst, m1_rready} = '0;
    {m1_awvalid, m1_awaddr, m1_awid, m1_awlen, m1_awsize, m1_awburst} = '0;
    {m1_wvalid, m1_wdata, m1_wstrb, m1_wlast, m1_bready} = '0;
    {io_master_arready, io_master_rvalid, io_master_rdata, io_master_rresp, io_master_rlast, io_master_rid} = '0;
    {io_master_awready, io_master_wready, io_master_bvalid, io_master_bresp, io_master_bid} = '0;

    // reset state, with requests and slave readies already asserted
    repeat (2) @(posedge clock);
    #1;
    io_master_arready = 1; io_master_awready = 1;
    m0_rready = 1; m1_rready = 1; m0_bready = 1; m1_bready = 1;
    m0_arvalid = 1; m1_awvalid = 1;
    #1;
    chk("rst_rstate", o_dbg_rstate, 0);
    chk("rst_wstate", o_dbg_wstate, 0);
    chk("rst_m0_arready", m0_arready, 0);
    chk("rst_m1_awready", m1_awready, 0);
    chk("rst_io_arvalid", io_master_arvalid, 0);
    chk("rst_io_awvalid", io_master_awvalid, 0);
    chk("rst_io_wvalid", io_master_wvalid, 0);
    chk("rst_io_rready", io_master_rready, 0);
    chk("rst_io_bready", io_master_bready, 0);
    chk("rst_io_araddr", io_master_araddr, 0);
    m0_arvalid = 0; m1_awvalid = 0;
    tick();
    reset = 1;
    tick();

    // T2: simultaneous AR from idle
`ifdef ARB_RR_EN
    first_m1 = 0;
`else
    first_m1 = 1;
`endif
    if (first_m1) begin
      exp_ar_q.push_back({8'd0, 4'h5, 32'h8000_2000});
      exp_ar_q.push_back({8'd0, 4'h2, 32'h8000_1000});
      exp_r1_q.push_back({1'b1, 4'h5, 32'h1111_0000});
      exp_r0_q.push_back({1'b1, 4'h2, 32'h2222_0000});
    end else begin
      exp_ar_q.push_back({8'd0, 4'h2, 32'h8000_1000});
      exp_ar_q.push_back({8'd0, 4'h5, 32'h8000_2000});
      exp_r0_q.push_back({1'b1, 4'h2, 32'h1111_0000});
      exp_r1_q.push_back({1'b1, 4'h5, 32'h2222_0000});
    end
    fork
      ar_req(0, 32'h8000_1000, 4'h2, 8'd0);
      ar_req(1, 32'h8000_2000, 4'h5, 8'd0);
      begin
        slave_r(1, 32'h1111_0000, first_m1 ? 4'h5 : 4'h2, 1);
        slave_r(1, 32'h2222_0000, first_m1 ? 4'h2 : 4'h5, 1);
      end
    join
    tick();

    // T1: m0 4-beat INCR burst, one cycle of request latency
    exp_ar_q.push_back({8'd3, 4'h1, 32'h8000_0000});
    for (int i = 0; i < 4; i++) exp_r0_q.push_back({(i == 3) ? 1'b1 : 1'b0, 4'h1, 32'h0000_00a0 + i});
    fork
      ar_req(0, 32'h8000_0000, 4'h1, 8'd3);
      begin
        #1 chk("t1_idle_latency", io_master_arvalid, 0);
        @(posedge clock); #2;
        chk("t1_ar_forwarded", io_master_arvalid, 1);
      end
      slave_r(4, 32'h0000_00a0, 4'h1, 1);
    join
    tick();

    // T3: m1 single write concurrent with m0 read
    exp_aw_q.push_back({8'd0, 4'h3, 32'ha000_03f8});
    exp_w_q.push_back({1'b1, 4'b0001, 32'h0000_0041});
    exp_b1_q.push_back({2'b00, 4'h3});
    exp_ar_q.push_back({8'd1, 4'h4, 32'h8000_0100});
    exp_r0_q.push_back({1'b0, 4'h4, 32'h0000_00b0});
    exp_r0_q.push_back({1'b1, 4'h4, 32'h0000_00b1});
    fork
      aw_req(1, 32'ha000_03f8, 4'h3, 8'd0);
      w_send(1, 1, 32'h0000_0041, 4'b0001);
      slave_w(8'hff, 1);
      slave_b(3, 2'b00, 4'h3);
      ar_req(0, 32'h8000_0100, 4'h4, 8'd1);
      slave_r(2, 32'h0000_00b0, 4'h4, 1);
    join
    tick();

    // T4: m1 AR held while m0 bursts
    exp_ar_q.push_back({8'd3, 4'h6, 32'h8000_0200});
    exp_ar_q.push_back({8'd0, 4'h7, 32'h8000_0300});
    for (int i = 0; i < 4; i++) exp_r0_q.push_back({(i == 3) ? 1'b1 : 1'b0, 4'h6, 32'h0000_00d0 + i});
    exp_r1_q.push_back({1'b1, 4'h7, 32'h0000_00e0});
    fork
      ar_req(0, 32'h8000_0200, 4'h6, 8'd3);
      begin tick(); ar_req(1, 32'h8000_0300, 4'h7, 8'd0); end
      begin tick(); watch_t4(); end
      begin slave_r(4, 32'h0000_00d0, 4'h6, 1); slave_r(1, 32'h0000_00e0, 4'h7, 1); end
    join
    tick();

    // T6: 3-beat m1 write with downstream wready 1,0,1
    exp_aw_q.push_back({8'd2, 4'h9, 32'ha000_0400});
    for (int i = 0; i < 3; i++) exp_w_q.push_back({(i == 2) ? 1'b1 : 1'b0, 4'hf, 32'h0000_00c0 + i});
    exp_b1_q.push_back({2'b00, 4'h9});
    fork
      aw_req(1, 32'ha000_0400, 4'h9, 8'd2);
      w_send(1, 3, 32'h0000_00c0, 4'hf);
      slave_w(8'b1111_1101, 3);
      slave_b(1, 2'b00, 4'h9);
      watch_t6();
    join
    tick();

    // T5: reset in the middle of a 4-beat burst, then a clean grant
    exp_ar_q.push_back({8'd3, 4'ha, 32'h8000_0400});
    exp_r0_q.push_back({1'b0, 4'ha, 32'h0000_00f0});
    exp_r0_q.push_back({1'b0, 4'ha, 32'h0000_00f1});
    fork
      ar_req(0, 32'h8000_0400, 4'ha, 8'd3);
      slave_r(2, 32'h0000_00f0, 4'ha, 0);
    join
    @(posedge clock); #2;
    io_master_rvalid = 1; io_master_rdata = 32'h0000_00f2; io_master_rid = 4'ha;
    chk("t5_pre_rdata", o_dbg_rstate, 2);
    #1 reset = 0;
    #1;
    chk("t5_rready_drop", io_master_rready, 0);
    chk("t5_arvalid_drop", io_master_arvalid, 0);
    chk("t5_m0_rvalid_drop", m0_rvalid, 0);
    chk("t5_rstate_idle", o_dbg_rstate, 0);
    io_master_rvalid = 0;
    tick();
    reset = 1;
    tick();
    exp_ar_q.push_back({8'd0, 4'hb, 32'h8000_0500});
    exp_r1_q.push_back({1'b1, 4'hb, 32'h0000_0099});
    fork
      ar_req(1, 32'h8000_0500, 4'hb, 8'd0);
      slave_r(1, 32'h0000_0099, 4'hb, 1);
    join
    repeat (3) tick();

    chk("end_ar_q_empty", exp_ar_q.size(), 0);
    chk("end_aw_q_empty", exp_aw_q.size(), 0);
    chk("end_w_q_empty", exp_w_q.size(), 0);
    chk("end_r0_q_empty", exp_r0_q.size(), 0);
    chk("end_r1_q_empty", exp_r1_q.size(), 0);
    chk("end_b1_q_empty", exp_b1_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
